// File: rtl/lcd_rd4.sv
// 4-bit HD44780 read engine: RS/RW setup, two E strobes on a divided tick, nibble capture.
// Latency k+4*DIV clks from accept (1<=k<=DIV); requests arriving while busy are dropped, rd_ready gates acceptance.
module lcd_rd4 #(
    parameter int unsigned DIV = 25000
) (
    input  logic       clk,
    input  logic       sw,
    input  logic       rd_req,
    input  logic       rd_rs,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       bf,
    output logic [6:0] ac,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    input  logic [3:0] db_in,
    output logic       db_oe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EN_H  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_EN_L  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [31:0] cnt;
    logic        tick;
    logic [2:0]  state;
    logic        rs_q;
    logic [3:0]  hi;
    logic [3:0]  lo;

    // Free-running phase divider; never resynchronised to requests.
    assign tick = (cnt == DIV - 32'd1);

    always_ff @(posedge clk) begin
        if (sw || tick) begin
            cnt <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign db_oe = ~lcd_rw;

    always_ff @(posedge clk) begin
        if (sw) begin
            state    <= S_IDLE;
            rs_q     <= 1'b0;
            hi       <= 4'h0;
            lo       <= 4'h0;
            lcd_rs   <= 1'b0;
            lcd_rw   <= 1'b0;
            lcd_en   <= 1'b0;
            rd_ready <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            bf       <= 1'b0;
            ac       <= 7'h00;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        rs_q     <= rd_rs;
                        lcd_rs   <= rd_rs;
                        lcd_rw   <= 1'b1;
                        rd_ready <= 1'b0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        lcd_en <= 1'b1;
                        state  <= S_EN_H;
                    end
                end
                S_EN_H: begin
                    // Capture on the edge that drops E, while the panel still drives DB.
                    if (tick) begin
                        hi     <= db_in;
                        lcd_en <= 1'b0;
                        state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        lcd_en <= 1'b1;
                        state  <= S_EN_L;
                    end
                end
                S_EN_L: begin
                    if (tick) begin
                        lo     <= db_in;
                        lcd_en <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (tick) begin
                        lcd_rw   <= 1'b0;
                        lcd_rs   <= 1'b0;
                        rd_data  <= {hi, lo};
                        if (!rs_q) begin
                            bf <= hi[3];
                            ac <= {hi[2:0], lo};
                        end
                        rd_valid <= 1'b1;
                        rd_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
